// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Read-side consumer for the async FIFO. Pops words through the
//               FIFO read port (1-cycle read latency) and re-emits them as a
//               valid/ready stream framed into BURST_LEN-word bursts, with
//               m_last on the final word of each burst. A 2-entry buffer
//               absorbs the read latency so the stream sustains one word per
//               clock under continuous m_ready.
// Ports       : rd_clk        - sole clock
//               rd_rstn       - synchronous active-low reset
//               enable        - start/continue bursting (sampled at burst ends)
//               fifo_rd_en    - FIFO pop strobe (combinational)
//               fifo_rd_data  - FIFO read data, valid the cycle after a pop
//               fifo_empty    - FIFO empty flag
//               m_data/m_valid/m_last/m_ready - output stream
//               burst_cnt     - completed bursts (wraps)
//               busy          - FSM active or words buffered/in flight
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  burst_cnt,
    output logic                  busy
);

    localparam logic [15:0] c_last_idx = 16'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [15:0]           r_word_idx;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [1:0]            r_buf_last;
    logic [CNT_WIDTH-1:0]  r_burst_cnt;

    logic w_pop;
    logic w_idx_last;
    logic w_room;
    logic w_rd_en;
    logic w_wr_slot;
    logic w_buf_drained;

    assign w_pop      = m_valid && m_ready;
    assign w_idx_last = (r_word_idx == c_last_idx);

    // Credit check: words held plus the word returning this cycle, minus the
    // word leaving this cycle, must leave a free slot for the next return.
    assign w_room  = ({1'b0, r_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
    assign w_rd_en = (r_state == S_READ) && !fifo_empty && w_room;

    // Slot the returning word lands in after this cycle's shift-out.
    assign w_wr_slot = (r_occ == 2'd2) || ((r_occ == 2'd1) && !w_pop);

    // Buffer will be empty after this edge and nothing is coming back, so
    // DRAIN can retire in the same edge that accepts the final word.
    assign w_buf_drained = !r_inflight &&
                           ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));

    // ------------------------------------------------------------------------
    // Burst FSM and word index
    // ------------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (!rd_rstn) begin
            r_state         <= S_IDLE;
            r_word_idx      <= 16'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && w_idx_last;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // enable only matters on the pop that closes a burst,
                    // which keeps bursts atomic once started.
                    if (w_rd_en) begin
                        if (w_idx_last) begin
                            r_word_idx <= 16'd0;
                            if (!enable) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_word_idx <= r_word_idx + 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_buf_drained) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // 2-entry output buffer, entry 0 is the head
    // ------------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (!rd_rstn) begin
            r_occ         <= 2'd0;
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= 2'b00;
        end else begin
            if (w_pop) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_last[0] <= r_buf_last[1];
            end
            // Later assignment wins, so a simultaneous shift and return into
            // slot 0 keeps the returning word.
            if (r_inflight) begin
                if (w_wr_slot) begin
                    r_buf_data[1] <= fifo_rd_data;
                    r_buf_last[1] <= r_inflight_last;
                end else begin
                    r_buf_data[0] <= fifo_rd_data;
                    r_buf_last[0] <= r_inflight_last;
                end
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // ------------------------------------------------------------------------
    // Completed-burst counter
    // ------------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (!rd_rstn) begin
            r_burst_cnt <= '0;
        end else if (w_pop && m_last) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf_data[0];
    assign m_last     = m_valid && r_buf_last[0];
    assign burst_cnt  = r_burst_cnt;
    assign busy       = (r_state != S_IDLE) || (r_occ != 2'd0) || r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench for fifo_burst_reader (BURST_LEN=4) with a
//               behavioural FIFO read port model (1-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 16;

    logic          rd_clk  = 1'b0;
    logic          rd_rstn = 1'b0;
    logic          enable  = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_rd_en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic [CW-1:0] burst_cnt;
    logic          busy;

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .CNT_WIDTH  (CW)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rstn      (rd_rstn),
        .enable       (enable),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .burst_cnt    (burst_cnt),
        .busy         (busy)
    );

    always #5 rd_clk = ~rd_clk;

    // Behavioural FIFO: written from the stimulus process, read on pops.
    logic [DW-1:0] fmem [256];
    logic [7:0]    wr_ptr = 8'd0;
    logic [7:0]    rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge rd_clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fmem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
        end
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [8:0]    got [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        fmem[wr_ptr] = d;
        wr_ptr       = wr_ptr + 8'd1;
    endtask

    // One clock: drive inputs on the falling edge, sample 1 ns later.
    task automatic cyc(input logic rst_n, input logic rdy, input logic en);
        @(negedge rd_clk);
        rd_rstn = rst_n;
        m_ready = rdy;
        enable  = en;
        #1;
        chk("rd_en_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
        if (prev_stall) begin
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
            chk("hold_last", {31'd0, m_last}, {31'd0, prev_last});
        end
        prev_stall = m_valid && !m_ready && rd_rstn;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready && rd_rstn) begin
            got.push_back({m_last, m_data});
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_valid"}, {31'd0, m_valid}, 32'd0);
        chk({nm, "_last"}, {31'd0, m_last}, 32'd0);
        chk({nm, "_data"}, {24'd0, m_data}, 32'd0);
        chk({nm, "_cnt"}, {16'd0, burst_cnt}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    endtask

    typedef struct {
        logic          rdy;
        logic          en;
        logic          valid;
        logic [DW-1:0] data;
        logic          last;
        logic          rd_en;
        logic [CW-1:0] cnt;
        logic          busy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Streaming with BURST_LEN=4, 0x10..0x17 in the FIFO, m_ready held.
        //               rdy   en    vld   data   last  rden  cnt    busy
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 16'd0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 16'd0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 16'd0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 1'b1, 16'd0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 1'b1, 16'd1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b1, 16'd1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 1'b0, 16'd1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h17, 1'b1, 1'b0, 16'd1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2, 1'b1};

        // ---------------- Reset with live inputs ----------------
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            chk_reset_outputs("reset");
        end

        // ---------------- Streaming (table) ----------------
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, tbl[i].rdy, tbl[i].en);
            chk($sformatf("stream%0d_valid", i), {31'd0, m_valid}, {31'd0, tbl[i].valid});
            if (tbl[i].valid) begin
                chk($sformatf("stream%0d_data", i), {24'd0, m_data}, {24'd0, tbl[i].data});
            end
            chk($sformatf("stream%0d_last", i), {31'd0, m_last}, {31'd0, tbl[i].last});
            chk($sformatf("stream%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, tbl[i].rd_en});
            chk($sformatf("stream%0d_cnt", i), {16'd0, burst_cnt}, {16'd0, tbl[i].cnt});
            chk($sformatf("stream%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
        end

        // ---------------- Backpressure ----------------
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        got.delete();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        for (int k = 0; k < 300 && got.size() < 8; k++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        end
        chk("bp_count", got.size(), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++) begin
            chk($sformatf("bp%0d_data", i), {24'd0, got[i][7:0]}, 32'h10 + i);
            chk($sformatf("bp%0d_last", i), {31'd0, got[i][8]}, {31'd0, (i % BL) == BL - 1});
        end
        cyc(1'b1, 1'b0, 1'b1);
        chk("bp_cnt", {16'd0, burst_cnt}, 32'd2);

        // ---------------- Underflow stall ----------------
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        got.delete();
        push(8'h20);
        push(8'h21);
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 1'b1);
        chk("uf_stall_count", got.size(), 32'd2);
        chk("uf_stall_valid", {31'd0, m_valid}, 32'd0);
        chk("uf_stall_cnt", {16'd0, burst_cnt}, 32'd0);
        push(8'hA0);
        push(8'hA1);
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 1'b1);
        chk("uf_count", got.size(), 32'd4);
        if (got.size() == 4) begin
            chk("uf0", {23'd0, got[0]}, {23'd0, 9'h020});
            chk("uf1", {23'd0, got[1]}, {23'd0, 9'h021});
            chk("uf2", {23'd0, got[2]}, {23'd0, 9'h0A0});
            chk("uf3", {23'd0, got[3]}, {23'd0, 9'h1A1});
        end
        chk("uf_cnt", {16'd0, burst_cnt}, 32'd1);

        // ---------------- Mid-burst reset ----------------
        // FSM is still READ at word index 0; 3 pops leave the index at 3.
        got.delete();
        push(8'h50);
        push(8'h51);
        push(8'h52);
        for (int k = 0; k < 20 && got.size() < 2; k++) cyc(1'b1, 1'b1, 1'b1);
        chk("mr_pre_count", got.size(), 32'd2);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk_reset_outputs("mr_rst");
        cyc(1'b0, 1'b0, 1'b1);
        chk_reset_outputs("mr_rst2");
        got.delete();
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        for (int k = 0; k < 30 && got.size() < 4; k++) cyc(1'b1, 1'b1, 1'b1);
        chk("mr_count", got.size(), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            chk($sformatf("mr%0d", i), {23'd0, got[i]},
                {23'd0, (i == 3), 8'h60 + 8'(i)});
        end
        cyc(1'b1, 1'b1, 1'b0);
        chk("mr_cnt", {16'd0, burst_cnt}, 32'd1);

        // ---------------- Enable drop ----------------
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        got.delete();
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        for (int k = 0; k < 30 && got.size() < 4; k++) begin
            cyc(1'b1, 1'b1, got.size() == 0);
        end
        chk("ed_count_at_last", got.size(), 32'd4);
        cyc(1'b1, 1'b1, 1'b0);
        chk("ed_busy_next", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b0);
        chk("ed_count", got.size(), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            chk($sformatf("ed%0d", i), {23'd0, got[i]},
                {23'd0, (i == 3), 8'h30 + 8'(i)});
        end
        chk("ed_fifo_left", {24'd0, wr_ptr - rd_ptr}, 32'd4);
        chk("ed_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("ed_busy", {31'd0, busy}, 32'd0);
        chk("ed_cnt", {16'd0, burst_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
